// File: rtl/wb_stage_pkg.sv
// Shared types for the write-back stage: register-file address/data types,
// the queued write-back entry, and the read/write port count macros.
`ifndef REG_AMT
`define REG_AMT 32
`endif
`ifndef READ_PORTS
`define READ_PORTS 2
`endif
`ifndef WRITE_PORTS
`define WRITE_PORTS 1
`endif

package wb_stage_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned RF_ADR_W     = $clog2(`REG_AMT);
  localparam int unsigned READ_PORTS_P = `READ_PORTS;

  typedef logic [RF_ADR_W-1:0] t_RFadrs;
  typedef logic [DATA_W-1:0]   t_data;

  // One buffered execute result; wen=0 means retire without an RF write.
  typedef struct packed {
    t_RFadrs dst;
    t_data   data;
    logic    wen;
  } t_wb_entry;

endpackage

// File: rtl/wb_stage_fifo.sv
// wb_fifo: circular in-order queue of write-back entries with head/tail
// pointers and an occupancy count. Storage is exported so the owner can
// scan pending destinations.
module wb_fifo
  import wb_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  t_wb_entry                push_entry,
  input  logic                     pop,
  output t_wb_entry                entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  t_wb_entry        mem_q [DEPTH];
  t_wb_entry        mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign entries = mem_q;
  assign head    = head_q;
  assign count   = count_q;

  // Next-state for storage, pointers and count; pointers wrap by width.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + 1'b1;
    end
    if (pop_ok) begin
      head_d = head_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Queue state registers; reset discards every pending entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage in front of RF write port 0. Queues execute
// results, drains one per cycle unless rf_hold, flags pending destinations
// on the RF read addresses and counts retired instructions.
// Optional feature macro: WB_BYPASS_EN builds the youngest-match forwarding
// mux; without it fwd_hit/fwd_data are tied low.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  t_RFadrs                ex_dst,
  input  t_data                  ex_data,
  input  logic                   ex_wen,
  input  logic                   rf_hold,
  output t_RFadrs                rf_dst,
  output t_data                  rf_datain,
  output logic                   rf_wr_en,
  input  t_RFadrs                src      [`READ_PORTS],
  output logic                   pend_hit [`READ_PORTS],
  output logic                   fwd_hit  [`READ_PORTS],
  output t_data                  fwd_data [`READ_PORTS],
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_W-1:0]       retire_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  t_wb_entry        entries [DEPTH];
  t_wb_entry        push_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W:0]   count;
  logic             full, empty;
  logic             accept, drain;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  assign ex_ready   = !full && !reset;
  assign accept     = ex_valid && ex_ready;
  assign drain      = !empty && !rf_hold;
  assign push_entry = '{dst: ex_dst, data: ex_data, wen: ex_wen};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (drain),
    .entries    (entries),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign occupancy  = count;
  assign retire_cnt = retire_cnt_q;

  // RF write port driven from the head entry; zeroed while empty.
  always_comb begin
    rf_dst    = '0;
    rf_datain = '0;
    rf_wr_en  = 1'b0;
    if (!empty) begin
      rf_dst    = entries[head].dst;
      rf_datain = entries[head].data;
      rf_wr_en  = drain && entries[head].wen;
    end
  end

  // Pending-write detect: any occupied wen=1 entry, head included, whose
  // dst equals the read address.
  always_comb begin
    for (int unsigned p = 0; p < `READ_PORTS; p++) begin
      pend_hit[p] = 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if ((PTR_W+1)'(k) < count) begin
          if (entries[head + PTR_W'(k)].wen &&
              entries[head + PTR_W'(k)].dst == src[p]) begin
            pend_hit[p] = 1'b1;
          end
        end
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Forward mux: scan oldest to youngest so the youngest match wins.
  always_comb begin
    for (int unsigned p = 0; p < `READ_PORTS; p++) begin
      fwd_hit[p]  = pend_hit[p];
      fwd_data[p] = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if ((PTR_W+1)'(k) < count) begin
          if (entries[head + PTR_W'(k)].wen &&
              entries[head + PTR_W'(k)].dst == src[p]) begin
            fwd_data[p] = entries[head + PTR_W'(k)].data;
          end
        end
      end
    end
  end
`else
  // No forwarding path: consumers must stall on pend_hit.
  always_comb begin
    for (int unsigned p = 0; p < `READ_PORTS; p++) begin
      fwd_hit[p]  = 1'b0;
      fwd_data[p] = '0;
    end
  end
`endif

  // Retired-instruction counter, wraps modulo 2^CNT_W.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (drain) begin
      retire_cnt_d = retire_cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with DEPTH=2, CNT_W=16.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int unsigned NRP = READ_PORTS_P;

  logic         clock = 1'b0;
  logic         reset;
  logic         ex_valid, ex_ready, ex_wen, rf_hold, rf_wr_en;
  t_RFadrs      ex_dst, rf_dst;
  t_data        ex_data, rf_datain;
  t_RFadrs      src      [NRP];
  logic         pend_hit [NRP];
  logic         fwd_hit  [NRP];
  t_data        fwd_data [NRP];
  logic [1:0]   occupancy;
  logic [15:0]  retire_cnt;

  int total = 0;
  int bad   = 0;

  wb_stage #(.DEPTH(2), .CNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_dst     (ex_dst),
    .ex_data    (ex_data),
    .ex_wen     (ex_wen),
    .rf_hold    (rf_hold),
    .rf_dst     (rf_dst),
    .rf_datain  (rf_datain),
    .rf_wr_en   (rf_wr_en),
    .src        (src),
    .pend_hit   (pend_hit),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data),
    .occupancy  (occupancy),
    .retire_cnt (retire_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input t_RFadrs d, input t_data v, input logic w);
    ex_valid = 1'b1;
    ex_dst   = d;
    ex_data  = v;
    ex_wen   = w;
  endtask

  initial begin
    reset    = 1'b1;
    ex_valid = 1'b0;
    ex_dst   = '0;
    ex_data  = '0;
    ex_wen   = 1'b0;
    rf_hold  = 1'b0;
    for (int i = 0; i < NRP; i++) src[i] = '0;

    // Reset held
    tick();
    tick();
    chk("rst_ready", ex_ready, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_wen", rf_wr_en, 0);
    reset = 1'b0;
    #1;
    chk("rel_ready", ex_ready, 1);
    chk("rel_occ", occupancy, 0);
    chk("rel_wen", rf_wr_en, 0);
    chk("rel_cnt", retire_cnt, 0);
    chk("rel_dst", rf_dst, 0);
    chk("rel_data", rf_datain, 0);
    chk("rel_pend", pend_hit[0], 0);
    chk("rel_fwdhit", fwd_hit[0], 0);
    chk("rel_fwddata", fwd_data[0], 0);

    // Single write: accept at edge 1, RF write at edge 2
    push(3, 32'hA5, 1'b1);
    src[0] = 3;
    #1;
    chk("unaccepted_pend", pend_hit[0], 0);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("w1_occ", occupancy, 1);
    chk("w1_wen", rf_wr_en, 1);
    chk("w1_dst", rf_dst, 3);
    chk("w1_data", rf_datain, 32'hA5);
    chk("w1_pend", pend_hit[0], 1);
    chk("w1_cnt", retire_cnt, 0);
`ifdef WB_BYPASS_EN
    chk("w1_fwdhit", fwd_hit[0], 1);
    chk("w1_fwddata", fwd_data[0], 32'hA5);
`else
    chk("w1_fwdhit", fwd_hit[0], 0);
`endif
    tick();
    chk("w1_cnt_after", retire_cnt, 1);
    chk("w1_occ_after", occupancy, 0);
    chk("w1_wen_after", rf_wr_en, 0);
    chk("w1_dst_after", rf_dst, 0);
    chk("w1_pend_after", pend_hit[0], 0);

    // Hold, fill with two writes to r5, youngest forwards
    rf_hold = 1'b1;
    push(5, 32'd1, 1'b1);
    tick();
    push(5, 32'd2, 1'b1);
    tick();
    ex_valid = 1'b0;
    src[0] = 5;
    src[1] = 3;
    #1;
    chk("full_occ", occupancy, 2);
    chk("full_ready", ex_ready, 0);
    chk("full_wen", rf_wr_en, 0);
    chk("full_dst", rf_dst, 5);
    chk("full_head_data", rf_datain, 1);
    chk("full_pend0", pend_hit[0], 1);
    chk("full_pend1", pend_hit[1], 0);
`ifdef WB_BYPASS_EN
    chk("full_fwdhit", fwd_hit[0], 1);
    chk("full_fwddata", fwd_data[0], 2);
`else
    chk("full_fwdhit", fwd_hit[0], 0);
    chk("full_fwddata", fwd_data[0], 0);
`endif
    // Offer while full: must be dropped
    push(7, 32'h77, 1'b1);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("full_drop_occ", occupancy, 2);
    rf_hold = 1'b0;
    #1;
    chk("hold_rel_wen", rf_wr_en, 1);
    chk("hold_rel_ready", ex_ready, 0);
    tick();
    chk("drain1_cnt", retire_cnt, 2);
    chk("drain1_occ", occupancy, 1);
    chk("drain1_data", rf_datain, 2);
    chk("drain1_ready", ex_ready, 1);
    tick();
    chk("drain2_cnt", retire_cnt, 3);
    chk("drain2_occ", occupancy, 0);
    chk("drain2_wen", rf_wr_en, 0);

    // Back-to-back with a wen=0 entry in the middle
    push(1, 32'h11, 1'b1);
    tick();
    #1;
    chk("s1_wen", rf_wr_en, 1);
    chk("s1_dst", rf_dst, 1);
    push(2, 32'h22, 1'b0);
    src[0] = 2;
    tick();
    chk("s2_occ", occupancy, 1);
    chk("s2_ready", ex_ready, 1);
    chk("s2_wen", rf_wr_en, 0);
    chk("s2_dst", rf_dst, 2);
    chk("s2_data", rf_datain, 32'h22);
    chk("s2_pend_nowen", pend_hit[0], 0);
    push(4, 32'h44, 1'b1);
    tick();
    ex_valid = 1'b0;
    #1;
    chk("s3_occ", occupancy, 1);
    chk("s3_wen", rf_wr_en, 1);
    chk("s3_data", rf_datain, 32'h44);
    tick();
    chk("s_cnt", retire_cnt, 6);
    chk("s_occ", occupancy, 0);

    // Reset with two entries held
    rf_hold = 1'b1;
    push(9, 32'h99, 1'b1);
    tick();
    push(10, 32'h100, 1'b1);
    tick();
    ex_valid = 1'b0;
    src[0] = 9;
    #1;
    chk("pre_rst_occ", occupancy, 2);
    rf_hold = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_wen", rf_wr_en, 0);
    chk("mid_rst_cnt", retire_cnt, 0);
    chk("mid_rst_pend", pend_hit[0], 0);
    chk("mid_rst_ready", ex_ready, 0);
    tick();
    chk("mid_rst_wen2", rf_wr_en, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", ex_ready, 1);

    // Counter wrap: sustained stream of wen=0 entries
    push(0, 32'h0, 1'b0);
    repeat (65535) tick();
    ex_valid = 1'b0;
    #1;
    chk("stream_occ", occupancy, 1);
    chk("stream_ready", ex_ready, 1);
    chk("stream_cnt", retire_cnt, 16'hFFFE);
    tick();
    chk("cnt_ffff", retire_cnt, 16'hFFFF);
    push(6, 32'h6, 1'b1);
    tick();
    ex_valid = 1'b0;
    tick();
    chk("cnt_wrap", retire_cnt, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the pipeline, sitting directly upstream of the register file write port. Buffers execute-stage results in a small in-order queue, drains one entry per cycle into the register file, and compares pending destinations against the register file read addresses so operand fetch sees results that are not yet written. Also keeps a retired-instruction counter for debug.

## Interface
- DEPTH, 2, queue entries; power of two, ≥2.
- CNT_W, 16, width of retired-instruction counter.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ex_valid  in  1  execute result offered.
- ex_ready  out  1  stage can accept (= not full).
- ex_dst  in  t_RFadrs  destination register.
- ex_data  in  t_data  result value.
- ex_wen  in  1  1 = instruction writes a register; 0 = retire only.
- rf_hold  in  1  write port unavailable this cycle; no drain.
- rf_dst  out  t_RFadrs  to RF write port 0 address.
- rf_datain  out  t_data  to RF write port 0 data.
- rf_wr_en  out  1  to RF write port 0 enable.
- src  in  t_RFadrs [`READ_PORTS]  RF read addresses, monitored.
- pend_hit  out  1 [`READ_PORTS]  src[i] matches a pending write.
- fwd_hit  out  1 [`READ_PORTS]  fwd_data[i] is valid, use it instead of RF dataout.
- fwd_data  out  t_data [`READ_PORTS]  forwarded value.
- occupancy  out  $clog2(DEPTH)+1  entries held.
- retire_cnt  out  CNT_W  retired instructions, wraps.

## Operation
- Queue: circular, head/tail pointers, count. Entry = {dst, data, wen}.
- Accept: ex_valid && ex_ready at a rising edge writes entry at tail, tail+1 mod DEPTH.
- ex_ready = (count < DEPTH); depends only on registered state, never on rf_hold or ex_valid.
- Drain: when count>0 && !rf_hold, head entry retires at the edge; head+1 mod DEPTH; retire_cnt+1 (mod 2^CNT_W).
- rf_wr_en = count>0 && !rf_hold && head.wen. rf_dst/rf_datain = head fields whenever count>0; 0 when empty.
- wen=0 entries drain in order with rf_wr_en=0; still counted as retired.
- Accept and drain in the same cycle: count unchanged, both pointers advance.
- Accept and drain never bypass each other: an entry accepted at edge N drains no earlier than edge N+1.
- pend_hit[i]: any occupied entry with wen=1 and dst==src[i], including the head being written this cycle (RF write lands at the edge, read is pre-edge).
- Multiple matches: youngest entry (closest to tail) supplies fwd_data.
- Unaccepted ex_* values are never forwarded.
- Reset mid-operation: pending entries discarded, no rf_wr_en asserted, pointers/count/retire_cnt to 0.

## Timing
- Reset values: ex_ready 0 while reset asserted, 1 first cycle after release; rf_wr_en 0; rf_dst 0; rf_datain 0; pend_hit/fwd_hit 0; fwd_data 0; occupancy 0; retire_cnt 0.
- Minimum latency: accept at edge N, RF written at edge N+1 (rf_wr_en high in cycle between).
- Throughput: one accept and one drain per cycle sustained with rf_hold=0; queue never fills.
- rf_hold=1 for DEPTH cycles with continuous input: full after DEPTH accepts; ex_ready=0 until first drain edge.
- pend_hit/fwd_* are combinational from src and registered queue; same cycle as src.

## Configuration
- WB_BYPASS_EN defined: fwd_hit = pend_hit, fwd_data from youngest match.
- Undefined: forwarding mux not built; fwd_hit and fwd_data tied 0; pend_hit still produced so decode stalls on hazards.

## Structure
- Shared package: t_RFadrs, t_data, `REG_AMT, `READ_PORTS, `WRITE_PORTS, new typedef t_wb_entry {t_RFadrs dst; t_data data; logic wen;}.
- One sub-module: wb_fifo (storage, pointers, count, full/empty); match/forward logic and retire counter in wb_stage.

## Test plan
- Reset release, ex_valid 0 -> ex_ready 1, occupancy 0, rf_wr_en 0, retire_cnt 0.
- Accept {dst=3,data=0xA5,wen=1} at edge 1 -> rf_wr_en=1, rf_dst=3, rf_datain=0xA5 in cycle after; retire_cnt 1 after edge 2.
- rf_hold=1, push dst=5 data 1 then dst=5 data 2 (DEPTH=2) -> ex_ready 0, src[0]=5 gives pend_hit 1, fwd_data 2 (BYPASS) / fwd_hit 0 (no BYPASS).
- wen=0 entry between two writes -> drains with rf_wr_en 0, retire_cnt increments by 3 total.
- Assert reset with 2 entries held and rf_hold=0 -> no further rf_wr_en, occupancy 0 immediately.
- retire_cnt at 0xFFFF plus one retire -> 0x0000.
